// File: rtl/cordic_arb_pkg.sv
// Shared types for the CORDIC job arbiter: requester id, result entry, FSM states.
package cordic_arb_pkg;

    localparam int CORDIC_DATA_W = 32;

    typedef logic req_id_t;

    typedef struct packed {
        req_id_t                  tag;
        logic [CORDIC_DATA_W-1:0] data;
    } res_entry_t;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/cordic_job_arbiter_if.sv
// Requester-side operand/result handshake bundle for both arbiter ports.
interface cordic_job_arbiter_if #(
    parameter int DATA_W = cordic_arb_pkg::CORDIC_DATA_W
);
    logic [1:0]          req_valid;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic [1:0]          rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cordic_arb_fifo.sv
// Synchronous FIFO with occupancy count and a same-edge clear (clear beats push/pop).
module cordic_arb_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; count/empty guard every read of it.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cordic_job_arbiter.sv
// Two-requester front end for the shared CORDIC: arbitrate, tag, buffer results with credits.
// CORDIC_ARB_PRIO_EN: requester 0 has strict priority (default build is round-robin).
module cordic_job_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int DATA_W  = CORDIC_DATA_W,
    parameter int MAX_OUT = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    cordic_job_arbiter_if.slave rq,
    input  logic                flush,
    output logic [DATA_W-1:0]   cordic_in,
    output logic                cordic_valid_in,
    input  logic [DATA_W-1:0]   cordic_out,
    input  logic                cordic_valid_out,
    output logic                busy,
    output logic                err_spurious
);
    localparam int CW = $clog2(MAX_OUT) + 1;

    typedef struct packed {
        req_id_t           tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cordic_in_q, cordic_in_d;
    logic              cordic_valid_in_q, cordic_valid_in_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [CW-1:0] inflight, res_cnt, occupancy, inflight_nxt, res_cnt_nxt;
    logic          tag_empty, tag_full, res_empty, res_full;
    req_id_t       grant, tag_head;
    entry_t        res_wdata, res_head;
    logic          run, credit, accept, ret, res_wr, res_clear, rsp_pop;
    logic [1:0]    ready;

    assign run       = (state_q == S_RUN);
    assign occupancy = inflight + res_cnt;
    assign credit    = (occupancy < CW'(MAX_OUT)) & ~tag_full;

`ifdef CORDIC_ARB_PRIO_EN
    assign grant = rq.req_valid[0] ? 1'b0 : rq.req_valid[1];
`else
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        grant = rr_ptr_q;
        if (!rq.req_valid[rr_ptr_q] && rq.req_valid[~rr_ptr_q]) grant = ~rr_ptr_q;
        rr_ptr_d = accept ? ~grant : rr_ptr_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) rr_ptr_q <= 1'b0;
        else          rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        ready = 2'b00;
        if (run && !flush && credit) ready[grant] = 1'b1;
    end

    assign rq.req_ready = ready;
    assign accept       = |(rq.req_valid & ready);

    // The tag FIFO count doubles as the in-flight counter.
    assign ret       = cordic_valid_out & ~tag_empty;
    assign res_wr    = ret & run;
    assign res_clear = run & flush;
    assign res_wdata = '{tag: tag_head, data: cordic_out};

    cordic_arb_fifo #(.WIDTH(1), .DEPTH(MAX_OUT)) u_tag_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (accept),
        .wdata (grant),
        .pop   (ret),
        .clear (1'b0),
        .rdata (tag_head),
        .count (inflight),
        .empty (tag_empty),
        .full  (tag_full)
    );

    cordic_arb_fifo #(.WIDTH($bits(entry_t)), .DEPTH(MAX_OUT)) u_res_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (res_wr),
        .wdata (res_wdata),
        .pop   (rsp_pop),
        .clear (res_clear),
        .rdata (res_head),
        .count (res_cnt),
        .empty (res_empty),
        .full  (res_full)
    );

    assign rq.rsp_valid = res_empty ? 2'b00 : 2'(2'b01 << res_head.tag);
    assign rq.rsp_data  = res_empty ? '0 : res_head.data;
    assign rsp_pop      = |(rq.rsp_valid & rq.rsp_ready);

    always_comb begin
        inflight_nxt = inflight + CW'(accept) - CW'(ret);
        res_cnt_nxt  = res_clear ? '0
                     : res_cnt + CW'(res_wr & ~res_full) - CW'(rsp_pop & ~res_empty);
        busy_d       = (inflight_nxt + res_cnt_nxt) != '0;
        err_d        = err_q | (cordic_valid_out & tag_empty);
        cordic_valid_in_d = accept;
        cordic_in_d       = '0;
        if (accept) cordic_in_d = grant ? rq.req_data[2*DATA_W-1:DATA_W] : rq.req_data[DATA_W-1:0];

        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (flush) state_d = S_DRAIN;
            S_DRAIN: if (inflight == '0) state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q           <= S_INIT;
            cordic_in_q       <= '0;
            cordic_valid_in_q <= 1'b0;
            busy_q            <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            cordic_in_q       <= cordic_in_d;
            cordic_valid_in_q <= cordic_valid_in_d;
            busy_q            <= busy_d;
            err_q             <= err_d;
        end
    end

    assign cordic_in       = cordic_in_q;
    assign cordic_valid_in = cordic_valid_in_q;
    assign busy            = busy_q;
    assign err_spurious    = err_q;

endmodule

// File: doc/cordic_job_arbiter.md
# cordic_job_arbiter

Shares the single CORDIC datapath between two requesters (bus bridge port 0, DMA/accelerator port 1). Arbitrates operand submissions, issues them to the CORDIC input, tags each job with its requester, and captures every result in a credit-protected result buffer. Each result returns in order to the requester that issued it. Sits between the requester-side valid/ready ports and the CORDIC `in_interface`/`valid_in_interface`/`valid_out_interface` signals, replacing the direct bridge-to-CORDIC hookup and the separate output FIFO.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width
- `MAX_OUT`, 8, max jobs in flight plus buffered; power of two, 2..64

Ports:
- `HCLK`  in  1  single clock; all logic on rising edge
- `HRESETn`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester operand valid
- `req_data`  in  2*DATA_W  operands; requester i at bits [i*DATA_W +: DATA_W]
- `req_ready`  out  2  per-requester accept
- `rsp_valid`  out  2  result valid, steered to the owning requester
- `rsp_data`  out  DATA_W  result data, shared by both requesters
- `rsp_ready`  in  2  per-requester result accept
- `flush`  in  1  one-cycle pulse: abort queued results and resynchronise
- `cordic_in`  out  DATA_W  operand to CORDIC
- `cordic_valid_in`  out  1  operand strobe to CORDIC
- `cordic_out`  in  DATA_W  CORDIC result
- `cordic_valid_out`  in  1  CORDIC result strobe; no backpressure possible
- `busy`  out  1  high when any job is in flight or buffered
- `err_spurious`  out  1  sticky: result arrived with no job outstanding

## Operation
- States: S_INIT, S_RUN, S_DRAIN. Reset enters S_INIT. S_INIT goes to S_RUN unconditionally after one cycle.
- S_RUN: `flush` goes to S_DRAIN. If in-flight is 0 when `flush` is seen, go to S_RUN the next cycle (one DRAIN cycle minimum).
- S_DRAIN: goes to S_RUN when in-flight == 0. `flush` is ignored in S_DRAIN.
- Counters:
  - `inflight` = issued jobs whose result has not yet returned.
  - `occupancy` = `inflight` + result-buffer count.
  - Credit is available when `occupancy` < MAX_OUT.
- Accept:
  - `req_ready[i]` = S_RUN & !flush & credit & grant==i.
  - Grant picks one valid requester, round-robin. The pointer moves past the winner after each accept.
  - Ready is never high for both requesters in the same cycle.
- Issue: an accept pushes the requester id onto the tag FIFO (depth MAX_OUT) and registers the operand onto `cordic_in`.
- Return: each `cordic_valid_out` pops one tag and decrements `inflight`.
  - In S_RUN, {tag, `cordic_out`} is written to the result FIFO (depth MAX_OUT).
  - In S_DRAIN, the result is discarded.
- Spurious result: `cordic_valid_out` with the tag FIFO empty is dropped and sets `err_spurious`. Only reset clears it.
- Delivery: the result FIFO head drives `rsp_data`.
  - `rsp_valid[head.tag]` = FIFO not empty.
  - A pop happens on `rsp_valid & rsp_ready` of the owner. `rsp_ready` of the non-owner is ignored.
  - Head-of-line blocking across requesters is intended.
- `flush` in S_RUN clears the result FIFO in the same edge. The tag FIFO and `inflight` are kept so later results stay aligned.
- Simultaneous accept and pop: `occupancy` is unchanged. Simultaneous `cordic_valid_out` and accept: the tag push and pop both occur.
- Widths: counters are clog2(MAX_OUT)+1 bits. No wrap is possible because credit gates accepts.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `cordic_in`=0, `cordic_valid_in`=0, `busy`=0, `err_spurious`=0. The round-robin pointer starts at requester 0 and all counters are 0.
- Accept in cycle N: `cordic_valid_in`=1 with `cordic_in`=operand for exactly cycle N+1, otherwise 0. Back-to-back accepts give back-to-back issues.
- `cordic_valid_out` in cycle M: `rsp_valid` rises in M+1 at the earliest (registered FIFO write).
- Pop in cycle K: the next entry is presented in K+1, so one result per cycle is sustained.
- `req_ready`, `rsp_valid` and `rsp_data` are combinational from registered state plus `req_valid`/`flush`.
- `busy` = (`occupancy` != 0), registered.
- Reset mid-operation discards all state immediately. Results arriving after reset are spurious and set `err_spurious`.

## Configuration
- `CORDIC_ARB_PRIO_EN` defined: strict priority, requester 0 always wins when valid. The round-robin pointer is removed.
- `CORDIC_ARB_PRIO_EN` undefined: round-robin as above. This is the default build.

## Structure
- Package `cordic_arb_pkg`:
  - `DATA_W` default
  - requester-id typedef (1 bit)
  - result-entry struct {tag, data}
  - state enum S_INIT/S_RUN/S_DRAIN
- Sub-module `cordic_arb_fifo`: synchronous FIFO with parameterised width/depth, push, pop, clear, count, empty/full. It is instantiated twice (tag FIFO, result FIFO).

## Test plan
- Reset, then both `req_valid`=1 continuously with operands 0x11/0x22 and CORDIC returning each operand +1 after 5 cycles → issues alternate 0x11,0x22,0x11…; `rsp_valid[0]` gets 0x12 and `rsp_valid[1]` gets 0x23 in issue order.
- MAX_OUT=8, `rsp_ready`=0 → exactly 8 accepts, then `req_ready`=0. One pop of the head result re-opens exactly one accept.
- Flush with 3 jobs in flight and 2 buffered → `rsp_valid`=0 next cycle; the 3 late results are discarded; return to S_RUN when `inflight`=0; the next job round-trips correctly.
- `cordic_valid_out` with nothing issued → no `rsp_valid`, `err_spurious`=1 and held until reset.
- Head result owned by requester 1 with `rsp_ready`=2'b01 → no pop, requester 0's result behind it waits. With `rsp_ready`=2'b10 → pop.
- With `CORDIC_ARB_PRIO_EN` defined, both valid continuously → only requester 0 is accepted until its `req_valid` drops.
